// File: rtl/adder_arb_pkg.sv
// Shared types and timing constants for the adder-sharing arbiter.
package adder_arb_pkg;

    typedef enum logic [1:0] {
        DRAIN = 2'd0,
        IDLE  = 2'd1,
        BUSY  = 2'd2
    } arb_state_t;

    // Issue-to-result latency of the shared adder, in cycles.
    localparam int ADDER_LAT    = 3;
    // Cycles spent ignoring the adder after reset so a pre-reset result is flushed.
    localparam int DRAIN_CYCLES = 3;

endpackage

// File: rtl/rr_picker.sv
// Combinational round-robin picker: first set request after last_i, wrapping.
module rr_picker #(
    parameter int N_REQ = 4,
    parameter int ID_W  = $clog2(N_REQ)
) (
    input  logic [N_REQ-1:0] req_i,
    input  logic [ID_W-1:0]  last_i,
    output logic [N_REQ-1:0] gnt_o,
    output logic [ID_W-1:0]  idx_o,
    output logic             any_o
);

    int cand;

    // Scan from last_i+1 around to last_i itself; first hit wins.
    always_comb begin
        gnt_o = '0;
        idx_o = '0;
        any_o = 1'b0;
        cand  = 0;
        for (int i = 1; i <= N_REQ; i++) begin
            cand = (int'(last_i) + i) % N_REQ;
            if (!any_o && req_i[ID_W'(cand)]) begin
                any_o               = 1'b1;
                idx_o               = ID_W'(cand);
                gnt_o[ID_W'(cand)]  = 1'b1;
            end
        end
    end

endmodule

// File: rtl/two_cycle_32_adder.sv
// 32-bit adder: operand capture, then low half, then high half.
// Valid_i in cycle T gives valid_o/res_o in cycle T+3. No reset on purpose.
module two_cycle_32_adder (
    input  logic        clk_i,
    input  logic        valid_i,
    input  logic [31:0] a_i,
    input  logic [31:0] b_i,
    output logic        valid_o,
    output logic [31:0] res_o
);

    logic [31:0] a_q, a_d, b_q, b_d;
    logic        v1_q, v1_d, v2_q, v2_d, v3_q, v3_d;
    logic [16:0] lo_q, lo_d;
    logic [15:0] ahi_q, ahi_d, bhi_q, bhi_d;
    logic [31:0] res_q, res_d;

    // Next-state for the three datapath stages.
    always_comb begin
        a_d   = a_i;
        b_d   = b_i;
        v1_d  = valid_i;
        lo_d  = {1'b0, a_q[15:0]} + {1'b0, b_q[15:0]};
        ahi_d = a_q[31:16];
        bhi_d = b_q[31:16];
        v2_d  = v1_q;
        res_d = {ahi_q + bhi_q + {15'd0, lo_q[16]}, lo_q[15:0]};
        v3_d  = v2_q;
    end

    // Pipeline registers; the arbiter's drain window covers the unreset state.
    always_ff @(posedge clk_i) begin
        a_q   <= a_d;
        b_q   <= b_d;
        v1_q  <= v1_d;
        lo_q  <= lo_d;
        ahi_q <= ahi_d;
        bhi_q <= bhi_d;
        v2_q  <= v2_d;
        res_q <= res_d;
        v3_q  <= v3_d;
    end

    assign valid_o = v3_q;
    assign res_o   = res_q;

endmodule

// File: rtl/adder_share_arbiter.sv
// Shares one non-pipelined adder among N_REQ requesters, round-robin,
// one operation in flight, tagged one-cycle response pulse per result.
module adder_share_arbiter
    import adder_arb_pkg::*;
#(
    parameter int N_REQ = 4,
    parameter int ID_W  = $clog2(N_REQ)
) (
    input  logic                clk_i,
    input  logic                rst_i,
    input  logic [N_REQ-1:0]    req_valid_i,
    output logic [N_REQ-1:0]    req_ready_o,
    input  logic [N_REQ*32-1:0] req_a_i,
    input  logic [N_REQ*32-1:0] req_b_i,
    output logic [N_REQ-1:0]    rsp_valid_o,
    output logic [31:0]         rsp_data_o,
    output logic [ID_W-1:0]     rsp_id_o,
    output logic                busy_o,
    output logic                err_o
);

    arb_state_t       state_q, state_d;
    logic [1:0]       cnt_q, cnt_d;
    logic [ID_W-1:0]  owner_q, owner_d;
    logic [ID_W-1:0]  last_q, last_d;
    logic             err_q, err_d;

    logic [N_REQ-1:0] pick_gnt;
    logic [ID_W-1:0]  pick_idx;
    logic             pick_any;
    logic             grant_en;
    logic             rsp_fire;
    logic             add_vi;
    logic [31:0]      a_mux, b_mux;
    logic             add_vld;
    logic [31:0]      add_res;

    rr_picker #(.N_REQ(N_REQ), .ID_W(ID_W)) u_pick (
        .req_i  (req_valid_i),
        .last_i (last_q),
        .gnt_o  (pick_gnt),
        .idx_o  (pick_idx),
        .any_o  (pick_any)
    );

    two_cycle_32_adder u_adder (
        .clk_i   (clk_i),
        .valid_i (add_vi),
        .a_i     (a_mux),
        .b_i     (b_mux),
        .valid_o (add_vld),
        .res_o   (add_res)
    );

    // Operand mux driven by the one-hot grant.
    always_comb begin
        a_mux = '0;
        b_mux = '0;
        for (int i = 0; i < N_REQ; i++) begin
            if (pick_gnt[i]) begin
                a_mux = req_a_i[i*32 +: 32];
                b_mux = req_b_i[i*32 +: 32];
            end
        end
    end

    // FSM next-state: drain after reset, grant when free, check result slot.
    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        owner_d  = owner_q;
        last_d   = last_q;
        err_d    = err_q;
        grant_en = 1'b0;
        rsp_fire = 1'b0;
        case (state_q)
            DRAIN: begin
                // Adder valid_o is deliberately ignored here.
                if (cnt_q <= 2'd1) begin
                    cnt_d   = '0;
                    state_d = IDLE;
                end else begin
                    cnt_d = cnt_q - 2'd1;
                end
            end
            IDLE: grant_en = 1'b1;
            BUSY: begin
                cnt_d = cnt_q + 2'd1;
                if (cnt_q == 2'(ADDER_LAT - 1)) begin
                    // Result slot: deliver, or flag a missing result and drop it.
                    rsp_fire = add_vld;
                    if (!add_vld) err_d = 1'b1;
                    grant_en = 1'b1;
                    state_d  = IDLE;
                end else if (add_vld) begin
                    err_d = 1'b1;
                end
            end
            default: state_d = DRAIN;
        endcase
        if (grant_en && pick_any) begin
            owner_d = pick_idx;
            last_d  = pick_idx;
            cnt_d   = '0;
            state_d = BUSY;
        end
    end

    // State registers; last_grant resets to N_REQ-1 so requester 0 goes first.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q <= DRAIN;
            cnt_q   <= 2'(DRAIN_CYCLES);
            owner_q <= '0;
            last_q  <= ID_W'(N_REQ - 1);
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            owner_q <= owner_d;
            last_q  <= last_d;
            err_q   <= err_d;
        end
    end

    assign add_vi      = grant_en & pick_any;
    assign req_ready_o = grant_en ? pick_gnt : '0;

    // Response outputs are zero whenever no pulse is being delivered.
    always_comb begin
        rsp_valid_o = '0;
        for (int i = 0; i < N_REQ; i++) begin
            rsp_valid_o[i] = rsp_fire && (owner_q == ID_W'(i));
        end
    end

    assign rsp_data_o = rsp_fire ? add_res : '0;
    assign rsp_id_o   = rsp_fire ? owner_q : '0;
    assign busy_o     = (state_q == DRAIN) ||
                        ((state_q == BUSY) && (cnt_q < 2'(ADDER_LAT - 1)));
    assign err_o      = err_q;

endmodule

// File: tb/tb_adder_share_arbiter.sv
// Directed bench for adder_share_arbiter with hand-computed expectations.
module tb_adder_share_arbiter;

    logic         clk = 1'b0;
    logic         rst;
    logic [3:0]   req_valid;
    logic [3:0]   req_ready;
    logic [127:0] req_a, req_b;
    logic [3:0]   rsp_valid;
    logic [31:0]  rsp_data;
    logic [1:0]   rsp_id;
    logic         busy, err;

    int total = 0;
    int bad   = 0;

    adder_share_arbiter #(.N_REQ(4)) dut (
        .clk_i       (clk),
        .rst_i       (rst),
        .req_valid_i (req_valid),
        .req_ready_o (req_ready),
        .req_a_i     (req_a),
        .req_b_i     (req_b),
        .rsp_valid_o (rsp_valid),
        .rsp_data_o  (rsp_data),
        .rsp_id_o    (rsp_id),
        .busy_o      (busy),
        .err_o       (err)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    // Advance to just after the next rising edge; inputs change here.
    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    // Check every output in the current cycle, then advance one cycle.
    task automatic step(input string t, input logic [3:0] rdy, input logic [3:0] rv,
                        input logic [31:0] d, input logic [1:0] id,
                        input logic bz, input logic er);
        #3;
        chk({t, ".rdy"},  {28'd0, req_ready}, {28'd0, rdy});
        chk({t, ".rv"},   {28'd0, rsp_valid}, {28'd0, rv});
        chk({t, ".data"}, rsp_data, d);
        chk({t, ".id"},   {30'd0, rsp_id}, {30'd0, id});
        chk({t, ".busy"}, {31'd0, busy}, {31'd0, bz});
        chk({t, ".err"},  {31'd0, err}, {31'd0, er});
        cyc();
    endtask

    task automatic set_req(input int i, input logic [31:0] a, input logic [31:0] b);
        req_a[i*32 +: 32] = a;
        req_b[i*32 +: 32] = b;
    endtask

    // Leaves the bench in the first cycle after reset was sampled.
    task automatic do_reset();
        rst = 1'b1;
        cyc();
        rst = 1'b0;
    endtask

    logic [31:0] sum3 [4];

    initial begin
        rst = 1'b1; req_valid = '0; req_a = '0; req_b = '0;
        sum3[0] = 32'h1111_1211; sum3[1] = 32'h2222_2323;
        sum3[2] = 32'h3333_3435; sum3[3] = 32'h4444_4547;
        cyc();

        // Single request from req0, pending during drain.
        do_reset();
        set_req(0, 32'h0000_FFFF, 32'h0000_0001);
        req_valid = 4'b0001;
        for (int c = 0; c < 3; c++) step("t1.drain", 4'b0, 4'b0, 32'h0, 2'd0, 1'b1, 1'b0);
        step("t1.grant", 4'b0001, 4'b0, 32'h0, 2'd0, 1'b0, 1'b0);
        req_valid = 4'b0;
        step("t1.w1", 4'b0, 4'b0, 32'h0, 2'd0, 1'b1, 1'b0);
        step("t1.w2", 4'b0, 4'b0, 32'h0, 2'd0, 1'b1, 1'b0);
        step("t1.rsp", 4'b0, 4'b0001, 32'h0001_0000, 2'd0, 1'b0, 1'b0);

        // Wrap-around sum, no error.
        set_req(0, 32'hFFFF_FFFF, 32'h0000_0002);
        req_valid = 4'b0001;
        step("t2.grant", 4'b0001, 4'b0, 32'h0, 2'd0, 1'b0, 1'b0);
        req_valid = 4'b0;
        step("t2.w1", 4'b0, 4'b0, 32'h0, 2'd0, 1'b1, 1'b0);
        step("t2.w2", 4'b0, 4'b0, 32'h0, 2'd0, 1'b1, 1'b0);
        step("t2.rsp", 4'b0, 4'b0001, 32'h0000_0001, 2'd0, 1'b0, 1'b0);

        // All four held valid: grants 0,1,2,3,0 every 3 cycles, responses overlap grants.
        do_reset();
        set_req(0, 32'h1111_1111, 32'h0000_0100);
        set_req(1, 32'h2222_2222, 32'h0000_0101);
        set_req(2, 32'h3333_3333, 32'h0000_0102);
        set_req(3, 32'h4444_4444, 32'h0000_0103);
        req_valid = 4'b1111;
        for (int c = 0; c < 3; c++) step("t3.drain", 4'b0, 4'b0, 32'h0, 2'd0, 1'b1, 1'b0);
        for (int k = 0; k < 5; k++) begin
            step("t3.gnt", 4'(1 << (k % 4)),
                 (k > 0) ? 4'(1 << (k - 1)) : 4'b0,
                 (k > 0) ? sum3[k-1] : 32'h0,
                 (k > 0) ? 2'(k - 1) : 2'd0, 1'b0, 1'b0);
            if (k == 4) req_valid = 4'b0;
            step("t3.w1", 4'b0, 4'b0, 32'h0, 2'd0, 1'b1, 1'b0);
            step("t3.w2", 4'b0, 4'b0, 32'h0, 2'd0, 1'b1, 1'b0);
        end
        step("t3.last", 4'b0, 4'b0001, sum3[0], 2'd0, 1'b0, 1'b0);

        // Two requesters with differing operands; last grant was req0.
        set_req(1, 32'h0000_0001, 32'h0000_0002);
        set_req(3, 32'h8000_0000, 32'h8000_0000);
        req_valid = 4'b1010;
        step("t4.g1", 4'b0010, 4'b0, 32'h0, 2'd0, 1'b0, 1'b0);
        req_valid = 4'b1000;
        step("t4.w1", 4'b0, 4'b0, 32'h0, 2'd0, 1'b1, 1'b0);
        step("t4.w2", 4'b0, 4'b0, 32'h0, 2'd0, 1'b1, 1'b0);
        step("t4.r1g3", 4'b1000, 4'b0010, 32'h0000_0003, 2'd1, 1'b0, 1'b0);
        req_valid = 4'b0;
        step("t4.one", 4'b0, 4'b0, 32'h0, 2'd0, 1'b1, 1'b0);
        step("t4.w2b", 4'b0, 4'b0, 32'h0, 2'd0, 1'b1, 1'b0);
        step("t4.r3", 4'b0, 4'b1000, 32'h0, 2'd3, 1'b0, 1'b0);
        step("t4.idle", 4'b0, 4'b0, 32'h0, 2'd0, 1'b0, 1'b0);

        // Reset one cycle after a grant aborts it; next grant goes to req0.
        set_req(2, 32'h0000_0005, 32'h0000_0006);
        req_valid = 4'b0100;
        step("t5.grant", 4'b0100, 4'b0, 32'h0, 2'd0, 1'b0, 1'b0);
        req_valid = 4'b0;
        rst = 1'b1;
        step("t5.rst", 4'b0, 4'b0, 32'h0, 2'd0, 1'b1, 1'b0);
        rst = 1'b0;
        set_req(0, 32'h0000_0007, 32'h0000_0008);
        req_valid = 4'b0101;
        for (int c = 0; c < 3; c++) step("t5.drain", 4'b0, 4'b0, 32'h0, 2'd0, 1'b1, 1'b0);
        step("t5.g0", 4'b0001, 4'b0, 32'h0, 2'd0, 1'b0, 1'b0);
        req_valid = 4'b0;
        step("t5.w1", 4'b0, 4'b0, 32'h0, 2'd0, 1'b1, 1'b0);
        step("t5.w2", 4'b0, 4'b0, 32'h0, 2'd0, 1'b1, 1'b0);
        step("t5.rsp", 4'b0, 4'b0001, 32'h0000_000F, 2'd0, 1'b0, 1'b0);

        // Missing adder result: sticky error, no response, grants continue.
        set_req(1, 32'd10, 32'd20);
        req_valid = 4'b0010;
        step("t6.g1", 4'b0010, 4'b0, 32'h0, 2'd0, 1'b0, 1'b0);
        set_req(2, 32'd100, 32'd200);
        req_valid = 4'b0100;
        step("t6.w1", 4'b0, 4'b0, 32'h0, 2'd0, 1'b1, 1'b0);
        step("t6.w2", 4'b0, 4'b0, 32'h0, 2'd0, 1'b1, 1'b0);
        force dut.add_vld = 1'b0;
        step("t6.miss", 4'b0100, 4'b0, 32'h0, 2'd0, 1'b0, 1'b0);
        release dut.add_vld;
        req_valid = 4'b0;
        step("t6.err", 4'b0, 4'b0, 32'h0, 2'd0, 1'b1, 1'b1);
        step("t6.w2", 4'b0, 4'b0, 32'h0, 2'd0, 1'b1, 1'b1);
        step("t6.r2", 4'b0, 4'b0100, 32'd300, 2'd2, 1'b0, 1'b1);
        step("t6.idle", 4'b0, 4'b0, 32'h0, 2'd0, 1'b0, 1'b1);
        do_reset();
        step("t6.clr", 4'b0, 4'b0, 32'h0, 2'd0, 1'b1, 1'b0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/adder_share_arbiter.md
# adder_share_arbiter

Round-robin scheduler that shares one `two_cycle_32_adder` instance among `N_REQ` measure-unit requesters. It accepts one operand pair at a time over a valid/ready handshake and drives the adder. It returns the 32-bit sum to the owning requester as a one-cycle tagged pulse. It also protects the adder, which is not pipelined and has no reset, from overlapping issues and from stale results after reset.

## Interface
- `N_REQ`, default 4: number of requesters, 2..16.
- `ID_W`, default `$clog2(N_REQ)`: width of the requester index.
- `clk_i` input 1: the only clock.
- `rst_i` input 1: reset, synchronous, active-high.
- `req_valid_i` input `N_REQ`: per-requester request valid.
- `req_ready_o` output `N_REQ`: per-requester grant, at most one bit high.
- `req_a_i` input `N_REQ`x32: per-requester operand A.
- `req_b_i` input `N_REQ`x32: per-requester operand B.
- `rsp_valid_o` output `N_REQ`: one-hot response pulse to the owning requester.
- `rsp_data_o` output 32: sum, shared by all requesters, qualified by `rsp_valid_o`.
- `rsp_id_o` output `ID_W`: index of the requester being answered.
- `busy_o` output 1: the arbiter cannot grant this cycle.
- `err_o` output 1: sticky; the adder failed to deliver a result on the expected cycle.

## Operation
- FSM states: `DRAIN`, `IDLE`, `BUSY`.
- **DRAIN**
  - Entered on reset. A counter is loaded with 3.
  - No grants are made, and adder `valid_o` is ignored, which flushes any operation in flight when reset hit.
  - Moves to `IDLE` when the counter reaches 0.
- **IDLE**
  - If any `req_valid_i` bit is set, the round-robin winner `w` is chosen, starting from `last_grant+1` mod `N_REQ`.
  - `req_ready_o[w]` = 1 combinationally.
  - Adder `valid_i` = 1, with `a_i`/`b_i` muxed from requester `w`.
  - `owner` <= `w`, `last_grant` <= `w`, counter cleared, next state `BUSY`.
- **BUSY**
  - The counter increments each cycle.
  - On counter == 2 (third cycle after issue), a response is expected:
    - If adder `valid_o` = 1: `rsp_valid_o[owner]` = 1, `rsp_id_o` = `owner`, `rsp_data_o` = `res_o`.
    - If adder `valid_o` = 0: `err_o` is set, no response is produced, and the owner's request is dropped.
  - In either case a new grant may be made in this same cycle, using the same rules as `IDLE`. The FSM then stays in `BUSY` with the new owner, or moves to `IDLE` if nothing is pending.
- Adder `valid_o` seen while in `BUSY` with counter != 2: `err_o` is set and the pulse is ignored.
- Arithmetic: sum = (A + B) mod 2^32; no carry-out or overflow flag.
- Requester rules:
  - Operands must be stable only in the handshake cycle.
  - `req_valid_i` must hold until handshake. Deasserting it earlier is legal, and such a request is simply not granted.
- Responses have no backpressure. Requesters must accept `rsp_valid_o` in the cycle it is asserted.
- `rsp_data_o` and `rsp_id_o` are 0 whenever no `rsp_valid_o` bit is set.
- `err_o` is cleared only by reset.

## Timing
- Reset values (applied the cycle after `rst_i` is sampled high):
  - state `DRAIN`; `req_ready_o`, `rsp_valid_o`, `rsp_data_o`, `rsp_id_o` = 0.
  - `busy_o` = 1, `err_o` = 0, `last_grant` = `N_REQ-1`, so requester 0 has first priority.
- After reset deasserts, `busy_o` stays 1 for 3 cycles; the first grant is possible in cycle 3.
- Latency: handshake in cycle T, response in cycle T+3.
- Throughput: one operation per 3 cycles with back-to-back grants. The response in cycle T+3 and the next grant in the same cycle is the required behaviour.
- `busy_o` = 1 in `DRAIN`, and in `BUSY` while counter < 2.
- Reset mid-operation: no response for the aborted operation is ever emitted, and the adder's late `valid_o` falls inside `DRAIN`.

## Structure
- Package `adder_arb_pkg`:
  - typedef `arb_state_t` enum {`DRAIN`, `IDLE`, `BUSY`}.
  - localparams `ADDER_LAT` = 3 and `DRAIN_CYCLES` = 3.
- Sub-module `rr_picker` (parameter `N_REQ`):
  - Inputs: request vector and `last_grant`.
  - Outputs: one-hot grant, winner index, `any` flag.
  - Purely combinational; reusable by other measure-unit arbiters.
- One `two_cycle_32_adder` instance inside this block.

## Test plan
- Single request: req0 with A=0x0000_FFFF, B=0x0000_0001 granted at T -> `rsp_valid_o`=4'b0001 at T+3, `rsp_data_o`=0x0001_0000, `rsp_id_o`=0.
- Wrap-around: A=0xFFFF_FFFF, B=0x0000_0002 -> `rsp_data_o`=0x0000_0001, `err_o` stays 0.
- All four requesters held valid continuously -> grants at T, T+3, T+6, T+9 in order 0,1,2,3, then 0 again. Each response lands 3 cycles after its grant, and a response coincides with the next grant.
- Two requesters with differing operands (req1 1+2, req3 0x8000_0000+0x8000_0000) -> `rsp_id_o` 1 then 3, with data 3 then 0; each `rsp_valid_o` is one-hot and exactly one cycle long.
- `rst_i` pulsed one cycle after a grant -> no `rsp_valid_o` ever for that operation, `busy_o`=1 for 3 cycles after reset, next grant goes to req0, and `err_o`=0.
- Adder `valid_o` forced to 0 at T+3 -> `err_o` rises at T+4 and stays high, no response, the arbiter keeps granting normally, and only `rst_i` clears `err_o`.
